// File: rtl/cpu_debug_loader_if.sv
// Host command/response stream and memory-target bus for cpu_debug_loader.
// The slave modport is the controller view; master is the host/memory side.
interface cpu_debug_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int NMEM   = 2
);
    localparam int SEL_W = (NMEM > 1) ? $clog2(NMEM) : 1;
    localparam int CMD_W = 4 + SEL_W + ADDR_W + DATA_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [SEL_W-1:0]  mem_sel;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cmd_valid, cmd_data, rsp_ready, mem_rdata,
        input  cmd_ready, rsp_valid, rsp_data, mem_sel, mem_we, mem_re, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready, mem_rdata,
        output cmd_ready, rsp_valid, rsp_data, mem_sel, mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu_debug_loader.sv
// Host-side load/run/dump controller: writes/reads attached memories, runs the
// CPU for an exact cycle budget and streams results back to the host.
module cpu_debug_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int NMEM   = 2
) (
    input  logic              clk,
    input  logic              rst,
    cpu_debug_loader_if.slave bus,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              err
);
    localparam int SEL_W = (NMEM > 1) ? $clog2(NMEM) : 1;
    localparam int CMD_W = 4 + SEL_W + ADDR_W + DATA_W;
    localparam logic [SEL_W:0] NMEM_L = (SEL_W + 1)'(NMEM);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_CAP, S_RSP, S_RUN, S_PCRSP
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_WRITE = 4'd1,
        OP_READ  = 4'd2,
        OP_RUN   = 4'd3,
        OP_DUMP  = 4'd4
    } op_t;

    state_t            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [SEL_W-1:0]  mem_sel_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              cpu_rst_q;
    logic              err_q;
    logic [DATA_W-1:0] cnt_q;
    logic              dump_q;

    logic [3:0]        cmd_op;
    logic [SEL_W-1:0]  cmd_sel;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_val;
    logic              cmd_illegal;
    logic              cmd_fire;
    logic [DATA_W-1:0] pc_ext;

    assign cmd_op      = bus.cmd_data[CMD_W-1 -: 4];
    assign cmd_sel     = bus.cmd_data[ADDR_W+DATA_W +: SEL_W];
    assign cmd_addr    = bus.cmd_data[DATA_W +: ADDR_W];
    assign cmd_val     = bus.cmd_data[0 +: DATA_W];
    assign cmd_illegal = (cmd_op > 4'd4) || ({1'b0, cmd_sel} >= NMEM_L);
    assign cmd_fire    = bus.cmd_valid && cmd_ready_q;

    // PC is zero-extended or truncated into the response word.
    generate
        if (ADDR_W >= DATA_W) begin : g_pc_trunc
            assign pc_ext = cpu_pc[DATA_W-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DATA_W-ADDR_W){1'b0}}, cpu_pc};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_sel_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            dump_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        if (cmd_illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            mem_sel_q   <= cmd_sel;
                            mem_addr_q  <= cmd_addr;
                            mem_wdata_q <= cmd_val;
                            case (op_t'(cmd_op))
                                OP_WRITE: begin
                                    mem_we_q    <= 1'b1;
                                    cmd_ready_q <= 1'b0;
                                    state_q     <= S_WR;
                                end
                                OP_READ: begin
                                    dump_q      <= 1'b0;
                                    mem_re_q    <= 1'b1;
                                    cmd_ready_q <= 1'b0;
                                    state_q     <= S_RD;
                                end
                                OP_DUMP: begin
                                    if (cmd_val != '0) begin
                                        dump_q      <= 1'b1;
                                        cnt_q       <= cmd_val;
                                        mem_re_q    <= 1'b1;
                                        cmd_ready_q <= 1'b0;
                                        state_q     <= S_RD;
                                    end
                                end
                                OP_RUN: begin
                                    cmd_ready_q <= 1'b0;
                                    if (cmd_val == '0) begin
                                        rsp_data_q  <= pc_ext;
                                        rsp_valid_q <= 1'b1;
                                        state_q     <= S_PCRSP;
                                    end else begin
                                        cpu_rst_q <= 1'b0;
                                        cnt_q     <= cmd_val;
                                        state_q   <= S_RUN;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_WR: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_RD: state_q <= S_CAP;
                S_CAP: begin
                    rsp_data_q  <= bus.mem_rdata;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        // cnt_q holds words still owed including the one just accepted
                        if (dump_q && cnt_q != DATA_W'(1)) begin
                            cnt_q      <= cnt_q - DATA_W'(1);
                            mem_addr_q <= mem_addr_q + ADDR_W'(1);
                            mem_re_q   <= 1'b1;
                            state_q    <= S_RD;
                        end else begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_q == DATA_W'(1)) begin
                        cpu_rst_q   <= 1'b1;
                        rsp_data_q  <= pc_ext;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_PCRSP;
                    end else begin
                        cnt_q <= cnt_q - DATA_W'(1);
                    end
                end
                S_PCRSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_rst       = cpu_rst_q;
    assign err           = err_q;
endmodule

// File: tb/tb_cpu_debug_loader.sv
// Directed bench for cpu_debug_loader with a behavioural memory bank and a
// counting CPU model; NMEM=3 so an out-of-range select is encodable.
module tb_cpu_debug_loader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int NMEM   = 3;

    logic              clk;
    logic              rst;
    logic              cpu_rst;
    logic [ADDR_W-1:0] cpu_pc;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    cpu_debug_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NMEM(NMEM)) bus ();

    cpu_debug_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NMEM(NMEM)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .cpu_pc  (cpu_pc),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DATA_W-1:0] mem [0:3][0:1023];

    // Read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_sel][bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_sel][bus.mem_addr];
    end

    always @(posedge clk) begin
        if (cpu_rst) cpu_pc <= '0;
        else         cpu_pc <= cpu_pc + ADDR_W'(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [1:0] sel,
                            input logic [9:0] addr, input logic [15:0] data);
        int n;
        n = 0;
        bus.cmd_data  = {op, sel, addr, data};
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic recv(output logic [15:0] data);
        int n;
        n = 0;
        bus.rsp_ready = 1'b1;
        while (!bus.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check("rsp_arrive", 32'(bus.rsp_valid), 32'd1);
        data = bus.rsp_data;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] dump_exp [4];
        int low_cnt;
        int bad;
        int n;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) tick();

        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_cpu_rst",   32'(cpu_rst),       32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_mem_strb",  32'({bus.mem_we, bus.mem_re}), 32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_err",       32'(err),           32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // WRITE then READ, with exact latencies
        send_cmd(4'd1, 2'd1, 10'h005, 16'h00A7);
        check("wr_we",    32'(bus.mem_we),    32'd1);
        check("wr_re",    32'(bus.mem_re),    32'd0);
        check("wr_sel",   32'(bus.mem_sel),   32'd1);
        check("wr_addr",  32'(bus.mem_addr),  32'h005);
        check("wr_wdata", 32'(bus.mem_wdata), 32'h00A7);
        tick();
        check("wr_we_pulse", 32'(bus.mem_we),    32'd0);
        check("wr_ready",    32'(bus.cmd_ready), 32'd1);

        send_cmd(4'd2, 2'd1, 10'h005, 16'h0000);
        check("rd_re",     32'(bus.mem_re),    32'd1);
        check("rd_valid1", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("rd_valid2", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("rd_valid3", 32'(bus.rsp_valid), 32'd1);
        check("rd_data",   32'(bus.rsp_data),  32'h00A7);
        recv(d);
        check("rd_done_valid", 32'(bus.rsp_valid), 32'd0);
        check("rd_done_ready", 32'(bus.cmd_ready), 32'd1);

        // DUMP across the address wrap
        send_cmd(4'd1, 2'd0, 10'h3FE, 16'h03FE);
        tick();
        send_cmd(4'd1, 2'd0, 10'h3FF, 16'h03FF);
        tick();
        send_cmd(4'd1, 2'd0, 10'h000, 16'h0000);
        tick();
        send_cmd(4'd1, 2'd0, 10'h001, 16'h0001);
        tick();
        dump_exp = '{16'h03FE, 16'h03FF, 16'h0000, 16'h0001};
        send_cmd(4'd4, 2'd0, 10'h3FE, 16'd4);
        for (int i = 0; i < 4; i++) begin
            check("dump_busy", 32'(bus.cmd_ready), 32'd0);
            recv(d);
            check("dump_word", 32'(d), 32'(dump_exp[i]));
        end
        check("dump_done_ready", 32'(bus.cmd_ready), 32'd1);

        // DUMP count 0 produces nothing
        send_cmd(4'd4, 2'd0, 10'h000, 16'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid || !bus.cmd_ready) bad++;
            tick();
        end
        check("dump0_idle", 32'(bad), 32'd0);

        // RUN 5 and RUN 0
        send_cmd(4'd3, 2'd0, 10'h000, 16'd5);
        low_cnt = 0;
        bad = 0;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            if (!cpu_rst) low_cnt++;
            if (bus.mem_we || bus.mem_re) bad++;
            tick();
            n++;
        end
        check("run5_low_cycles", 32'(low_cnt), 32'd5);
        check("run5_mem_quiet",  32'(bad),     32'd0);
        check("run5_rst_back",   32'(cpu_rst), 32'd1);
        recv(d);
        check("run5_pc", 32'(d), 32'd4);

        send_cmd(4'd3, 2'd0, 10'h000, 16'd0);
        check("run0_cpu_rst", 32'(cpu_rst),       32'd1);
        check("run0_valid",   32'(bus.rsp_valid), 32'd1);
        recv(d);
        check("run0_pc", 32'(d), 32'd0);

        // Backpressure on READ
        send_cmd(4'd2, 2'd1, 10'h005, 16'h0000);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.rsp_valid || bus.rsp_data != 16'h00A7 || bus.cmd_ready) bad++;
            tick();
        end
        check("bp_hold", 32'(bad), 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_accept", 32'(bus.rsp_valid), 32'd0);

        // Illegal opcode, then illegal select after clearing err
        send_cmd(4'hF, 2'd0, 10'h000, 16'h0000);
        check("ill_op_err",   32'(err),           32'd1);
        check("ill_op_ready", 32'(bus.cmd_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("err_cleared", 32'(err), 32'd0);
        send_cmd(4'd2, 2'(NMEM), 10'h005, 16'h0000);
        check("ill_sel_err",   32'(err),           32'd1);
        check("ill_sel_ready", 32'(bus.cmd_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid || bus.mem_re) bad++;
            tick();
        end
        check("ill_sel_no_rsp", 32'(bad), 32'd0);
        send_cmd(4'd1, 2'd1, 10'h009, 16'h5555);
        check("post_ill_we",   32'(bus.mem_we),    32'd1);
        check("post_ill_addr", 32'(bus.mem_addr),  32'h009);
        tick();
        send_cmd(4'd2, 2'd1, 10'h009, 16'h0000);
        recv(d);
        check("post_ill_rd", 32'(d), 32'h5555);

        // Reset during the second word of a DUMP
        send_cmd(4'd4, 2'd0, 10'h000, 16'd8);
        recv(d);
        check("dump8_word0", 32'(d), 32'h0000);
        rst = 1'b1;
        tick();
        check("dumprst_valid",   32'(bus.rsp_valid), 32'd0);
        check("dumprst_cpu_rst", 32'(cpu_rst),       32'd1);
        check("dumprst_err",     32'(err),           32'd0);
        check("dumprst_re",      32'(bus.mem_re),    32'd0);
        rst = 1'b0;
        tick();
        check("dumprst_ready", 32'(bus.cmd_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid) bad++;
            tick();
        end
        check("dumprst_no_rsp", 32'(bad), 32'd0);

        // Reset mid-RUN
        send_cmd(4'd3, 2'd0, 10'h000, 16'd20);
        repeat (3) tick();
        check("midrun_released", 32'(cpu_rst), 32'd0);
        rst = 1'b1;
        tick();
        check("runrst_cpu_rst", 32'(cpu_rst),       32'd1);
        check("runrst_valid",   32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("runrst_ready", 32'(bus.cmd_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.rsp_valid || !cpu_rst) bad++;
            tick();
        end
        check("runrst_aborted", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cpu_debug_loader.md
Name: cpu_debug_loader

Overview:
Host-side load/run/dump controller for the simple CPU. It makes memory initialisation and result extraction synthesizable, replacing testbench back-door access. It accepts packed commands over a valid/ready stream and writes or reads any of NMEM attached memories (instruction, data, register bank, ...). It also holds the CPU in reset, then releases it for an exact cycle budget. It returns read, dump and run results over a valid/ready response stream.

Parameters:
ADDR_W, 10, memory word-address width (shared by all targets)
DATA_W, 16, memory data width and response width
NMEM, 2, number of selectable memory targets
SEL_W, (NMEM>1 ? $clog2(NMEM) : 1), target-select field width (derived)
CMD_W, 4+SEL_W+ADDR_W+DATA_W, command word width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_data  in  CMD_W  {op[3:0], sel, addr, data}, op in MSBs
rsp_valid  out  1  response word present
rsp_ready  in  1  host accepts response
rsp_data  out  DATA_W  response word
mem_sel  out  SEL_W  target memory index
mem_we  out  1  write strobe
mem_re  out  1  read strobe
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data from selected target, valid the cycle after mem_re
cpu_rst  out  1  CPU reset, active-high
cpu_pc  in  ADDR_W  CPU program counter
err  out  1  sticky illegal-opcode flag

Behaviour:
- Reset values: cmd_ready=0 during rst, then 1 (IDLE). cpu_rst=1. rsp_valid=0, rsp_data=0. mem_we=0, mem_re=0, mem_sel/addr/wdata=0. err=0.
- Handshake: a transfer occurs when valid&&ready on the same edge. cmd_ready=1 only in IDLE. rsp_valid, once high, holds and rsp_data stays stable until rsp_ready.
- Opcodes:
  - 0 NOP: no action.
  - 1 WRITE: write data to mem[sel][addr].
  - 2 READ: return mem[sel][addr].
  - 3 RUN: release CPU for data cycles.
  - 4 DUMP: return data words from mem[sel], starting at addr.
  - 5..15: illegal.
- sel >= NMEM is treated as illegal.
- FSM states: IDLE, WR, RD, CAP, RSP, RUN, PCRSP.
  - IDLE: on accept, latch sel/addr/data and go to the state for the opcode.
  - NOP: stays in IDLE.
  - Illegal op or sel: err<=1, stay in IDLE; the command is consumed and no response is sent.
  - WR: mem_we=1 for exactly one cycle with the latched fields, then IDLE. Latency is accept -> mem_we in 1 cycle.
  - RD: mem_re=1 for one cycle, then CAP.
  - CAP: rsp_data<=mem_rdata, rsp_valid<=1, then RSP.
  - RSP: wait for rsp_ready.
    - READ: done, go to IDLE.
    - DUMP: remaining-1; addr+1 modulo 2^ADDR_W (wraps from 2^ADDR_W-1 to 0); if remaining is 0 go to IDLE, else RD.
  - Latency: accept -> rsp_valid in 3 cycles. A zero-stall dump produces one word per 3 cycles.
  - DUMP with count 0: return to IDLE immediately, no response.
  - RUN: cycle counter = data (DATA_W bits). cpu_rst=0 for exactly data consecutive cycles, starting the cycle after accept. After the last cycle cpu_rst=1 again. Then go to PCRSP.
  - RUN with count 0: cpu_rst never deasserts; go straight to PCRSP.
  - PCRSP: rsp_data = cpu_pc sampled in the final released cycle (the reset-state pc if count 0), zero-extended or truncated to DATA_W. Handshake as in RSP, then IDLE.
- mem_we and mem_re are never both high. mem_we and mem_re stay 0 during RUN, when the CPU owns the memories. cpu_rst stays 1 in every state except RUN.
- rst mid-operation (any state): the next cycle is the reset state. Any pending response is dropped, the dump or run is aborted, and cpu_rst=1.
- err clears only on rst.

Test Plan:
- WRITE sel=1 addr=0x005 data=0x00A7, then READ sel=1 addr=0x005 -> one mem_we pulse with addr 5 / wdata 0x00A7; rsp_data=0x00A7 exactly 3 cycles after READ accept.
- DUMP sel=0 addr=0x3FE count=4, memory preloaded with addr value -> responses 0x03FE, 0x03FF, 0x0000, 0x0001 (address wraps); cmd_ready stays 0 until the 4th handshake.
- RUN count=5 with a CPU incrementing pc each cycle from 0 -> cpu_rst low exactly 5 cycles; single response rsp_data=pc sampled in the final released cycle; RUN count=0 -> cpu_rst never low, response returns the reset pc.
- Backpressure: READ with rsp_ready=0 for 10 cycles -> rsp_valid held, rsp_data stable, cmd_ready=0; accepted on the first rsp_ready=1 cycle.
- Illegal op 0xF, then sel=NMEM -> err=1, no response, cmd_ready=1 next cycle; a subsequent valid WRITE still executes.
- rst asserted during the 2nd word of a DUMP count=8, and separately mid-RUN -> next cycle rsp_valid=0, cpu_rst=1, err=0, cmd_ready=1 after rst drops.
